hamm_err_monitor: RTL and testbench

HAMM_ERR_MONITOR -- requirements
Module: hamm_err_monitor

---
 rtl/hamm_pkg.sv | 14 +
 rtl/hamm_skid_buf.sv | 73 +++++++
 rtl/hamm_err_monitor.sv | 145 ++++++++++++++
 tb/tb_hamm_err_monitor.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamm_pkg.sv
// Shared definitions for the Hamming error monitor: data/syndrome widths
// and the health FSM state encoding.
package hamm_pkg;

  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2
  } hamm_state_e;

endpackage

// File: rtl/hamm_skid_buf.sv
// Two-entry skid buffer. The main register drives the output; the skid
// register catches one extra word when the consumer stalls. in_ready is
// registered and drops only once the skid entry is occupied.
module hamm_skid_buf #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_reg, main_valid_next;
  logic [WIDTH-1:0] main_data_reg,  main_data_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
  logic             in_ready_reg,   in_ready_next;
  logic             push;

  assign push = in_valid && in_ready_reg;

  // Next-state for both entries; the main entry only changes when it is
  // empty or being consumed, so the output holds steady under a stall.
  always_comb begin
    main_valid_next = main_valid_reg;
    main_data_next  = main_data_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    if (skid_valid_reg) begin
      if (out_ready) begin
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_reg || out_ready) begin
        main_valid_next = 1'b1;
        main_data_next  = in_data;
      end else begin
        skid_valid_next = 1'b1;
        skid_data_next  = in_data;
      end
    end else if (main_valid_reg && out_ready) begin
      main_valid_next = 1'b0;
    end
    in_ready_next = !skid_valid_next;
  end

  // Buffer registers; reset empties both entries and holds in_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;

endmodule

// File: rtl/hamm_err_monitor.sv
// Hamming decoder error monitor: forwards clean/corrected words through a
// skid buffer, drops uncorrectable words, keeps saturating error totals and
// a windowed double-bit health FSM (OK/WARN/ALARM).
// Optional syndrome log enabled by defining HAMM_SYNDROME_LOG_EN.
module hamm_err_monitor
  import hamm_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int ALARM_THRESH = 4,
  parameter int WINDOW_LEN   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              single_bit_error,
  input  logic              double_bit_error,
  input  logic [SYN_W-1:0]  syndrome,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic [CNT_W-1:0]  sb_count,
  output logic [CNT_W-1:0]  db_count,
  output logic              alarm,
  input  logic              clr
`ifdef HAMM_SYNDROME_LOG_EN
  ,
  output logic [SYN_W-1:0]  last_syndrome
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW_LEN - 1);
  localparam logic [7:0]       THRESH   = 8'(ALARM_THRESH);

  logic              accept;
  logic              is_sb;
  logic              is_db;
  logic              win_wrap;
  logic [7:0]        win_db_base;
  logic [DATA_W:0]   skid_out;

  logic [CNT_W-1:0]  sb_cnt_reg, sb_cnt_next;
  logic [CNT_W-1:0]  db_cnt_reg, db_cnt_next;
  logic [15:0]       win_cnt_reg, win_cnt_next;
  logic [7:0]        win_db_reg, win_db_next;
  hamm_state_e       state_reg, state_next;

  assign accept = in_valid && in_ready;
  assign is_db  = double_bit_error;
  assign is_sb  = single_bit_error && !double_bit_error;

  // Only words without an uncorrectable error enter the output path.
  hamm_skid_buf #(
    .WIDTH(DATA_W + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid && !double_bit_error),
    .in_ready (in_ready),
    .in_data  ({single_bit_error, in_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (skid_out)
  );

  assign out_corr = skid_out[DATA_W];
  assign out_data = skid_out[DATA_W-1:0];

  // A word accepted on the wrap cycle belongs to the new window, so its
  // double-bit contribution is added on top of a cleared window count.
  assign win_wrap    = (win_cnt_reg == WIN_LAST);
  assign win_db_base = win_wrap ? 8'd0 : win_db_reg;

  // Counter, window and FSM next-state; clr overrides any same-cycle accept.
  always_comb begin
    sb_cnt_next  = sb_cnt_reg;
    db_cnt_next  = db_cnt_reg;
    win_cnt_next = win_cnt_reg;
    win_db_next  = win_db_reg;
    state_next   = state_reg;
    if (clr) begin
      sb_cnt_next  = '0;
      db_cnt_next  = '0;
      win_cnt_next = '0;
      win_db_next  = '0;
      state_next   = ST_OK;
    end else if (accept) begin
      if (is_sb && sb_cnt_reg != CNT_MAX) sb_cnt_next = sb_cnt_reg + CNT_W'(1);
      if (is_db && db_cnt_reg != CNT_MAX) db_cnt_next = db_cnt_reg + CNT_W'(1);
      win_cnt_next = win_wrap ? 16'd0 : win_cnt_reg + 16'd1;
      win_db_next  = win_db_base + 8'(is_db && win_db_base != 8'hFF);
      case (state_reg)
        ST_OK: begin
          if (is_db) state_next = (win_db_next >= THRESH) ? ST_ALARM : ST_WARN;
        end
        ST_WARN: begin
          if (win_db_next >= THRESH)              state_next = ST_ALARM;
          else if (win_wrap && win_db_next == '0) state_next = ST_OK;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Counter, window and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_cnt_reg  <= '0;
      db_cnt_reg  <= '0;
      win_cnt_reg <= '0;
      win_db_reg  <= '0;
      state_reg   <= ST_OK;
    end else begin
      sb_cnt_reg  <= sb_cnt_next;
      db_cnt_reg  <= db_cnt_next;
      win_cnt_reg <= win_cnt_next;
      win_db_reg  <= win_db_next;
      state_reg   <= state_next;
    end
  end

  assign sb_count = sb_cnt_reg;
  assign db_count = db_cnt_reg;
  assign alarm    = (state_reg == ST_ALARM);

`ifdef HAMM_SYNDROME_LOG_EN
  logic [SYN_W-1:0] last_syn_reg;

  // Capture the syndrome of every accepted erroneous word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             last_syn_reg <= '0;
    else if (clr)                                           last_syn_reg <= '0;
    else if (accept && (single_bit_error || double_bit_error)) last_syn_reg <= syndrome;
  end

  assign last_syndrome = last_syn_reg;
`else
  logic unused_syndrome;
  assign unused_syndrome = ^syndrome;
`endif

endmodule

// File: tb/tb_hamm_err_monitor.sv
// Self-checking bench for hamm_err_monitor: directed scenarios plus a
// randomized run, all scored against a behavioural model of the monitor.
`timescale 1ns/1ps
module tb_hamm_err_monitor;

  localparam int CNT_W = 4;
  localparam int THR   = 4;
  localparam int WIN   = 256;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'h00;
  logic             single_bit_error = 1'b0;
  logic             double_bit_error = 1'b0;
  logic [3:0]       syndrome = 4'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             out_corr;
  logic [CNT_W-1:0] sb_count;
  logic [CNT_W-1:0] db_count;
  logic             alarm;
  logic             clr = 1'b0;
`ifdef HAMM_SYNDROME_LOG_EN
  logic [3:0]       last_syndrome;
`endif

  always #5 clk = ~clk;

  hamm_err_monitor #(
    .CNT_W       (CNT_W),
    .ALARM_THRESH(THR),
    .WINDOW_LEN  (WIN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .single_bit_error(single_bit_error),
    .double_bit_error(double_bit_error),
    .syndrome        (syndrome),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_corr        (out_corr),
    .sb_count        (sb_count),
    .db_count        (db_count),
    .alarm           (alarm),
    .clr             (clr)
`ifdef HAMM_SYNDROME_LOG_EN
    ,
    .last_syndrome   (last_syndrome)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: expected output words plus the monitor's statistics.
  logic [8:0] exp_q[$];
  int         m_sb, m_db, m_wpos, m_wdb, m_state;   // m_state: 0 OK, 1 WARN, 2 ALARM
  logic [3:0] m_syn;
  bit         last_acc;

  task automatic model_reset();
    exp_q.delete();
    m_sb = 0; m_db = 0; m_wpos = 0; m_wdb = 0; m_state = 0; m_syn = 4'h0;
  endtask

  task automatic model_accept(input logic [7:0] d, input bit sb, input bit db, input logic [3:0] syn);
    bit wrap;
    if (!db) exp_q.push_back({sb, d});
    if (db) m_db = (m_db < CMAX) ? m_db + 1 : m_db;
    else if (sb) m_sb = (m_sb < CMAX) ? m_sb + 1 : m_sb;
    if (sb || db) m_syn = syn;
    wrap   = (m_wpos == WIN - 1);
    m_wpos = wrap ? 0 : m_wpos + 1;
    if (wrap) m_wdb = 0;
    if (db) m_wdb = m_wdb + 1;
    if (m_state == 0 && db)      m_state = (m_wdb >= THR) ? 2 : 1;
    else if (m_state == 1) begin
      if (m_wdb >= THR)              m_state = 2;
      else if (wrap && m_wdb == 0)   m_state = 0;
    end
  endtask

  task automatic model_clear();
    m_sb = 0; m_db = 0; m_wpos = 0; m_wdb = 0; m_state = 0; m_syn = 4'h0;
  endtask

  // One clock: score any output transfer, update the model with this edge's
  // accept/clear, then advance to the next falling edge.
  task automatic cycle();
    bit acc, pop;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      $display("out data=%02h corr=%0b", out_data, out_corr);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected got=%03h required=none", {out_corr, out_data});
      end else begin
        if ({out_corr, out_data} !== exp_q[0]) begin
          bad++;
          $display("FAIL out_word got=%03h required=%03h", {out_corr, out_data}, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
    if (acc) model_accept(in_data, single_bit_error, double_bit_error, syndrome);
    if (clr) model_clear();
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit sb, input bit db, input logic [3:0] syn);
    in_valid = v; in_data = d; single_bit_error = sb; double_bit_error = db; syndrome = syn;
  endtask

  task automatic pulse_clr();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle();
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain pending=%0d out_valid=%b required pending=0 out_valid=0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (in_ready  !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    total++; if (out_data  !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h required=00", out_data); end
    total++; if (out_corr  !== 1'b0) begin bad++; $display("FAIL rst_out_corr got=%b required=0", out_corr); end
    total++; if (sb_count  !== '0)   begin bad++; $display("FAIL rst_sb_count got=%0d required=0", sb_count); end
    total++; if (db_count  !== '0)   begin bad++; $display("FAIL rst_db_count got=%0d required=0", db_count); end
    total++; if (alarm     !== 1'b0) begin bad++; $display("FAIL rst_alarm got=%b required=0", alarm); end
`ifdef HAMM_SYNDROME_LOG_EN
    total++; if (last_syndrome !== 4'h0) begin bad++; $display("FAIL rst_last_syndrome got=%h required=0", last_syndrome); end
`endif
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_early got=%b required=0", in_ready); end
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready_edge got=%b required=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'(i - 1)) begin
          bad++;
          $display("FAIL stream_latency idx=%0d got valid=%b data=%h required valid=1 data=%h", i - 1, out_valid, out_data, 8'(i - 1));
        end
      end
      if (i < 256) begin
        drive(1'b1, 8'(i), 1'b0, 1'b0, 4'h0);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready idx=%0d got=%b required=1", i, in_ready); end
      end else begin
        drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
      end
      cycle();
    end
    total++;
    if (sb_count !== '0 || db_count !== '0) begin
      bad++; $display("FAIL stream_counts got sb=%0d db=%0d required sb=0 db=0", sb_count, db_count);
    end
    drain();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 8'hA5, 1'b1, 1'b0, 4'h6);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_corr !== 1'b1) begin
      bad++; $display("FAIL single_out got valid=%b data=%h corr=%b required 1/a5/1", out_valid, out_data, out_corr);
    end
    total++; if (sb_count !== CNT_W'(1)) begin bad++; $display("FAIL single_sb_count got=%0d required=1", sb_count); end
`ifdef HAMM_SYNDROME_LOG_EN
    total++; if (last_syndrome !== 4'h6) begin bad++; $display("FAIL single_syndrome got=%h required=6", last_syndrome); end
`endif
    drain();
  endtask

  task automatic test_alarm();
    out_ready = 1'b1;
    pulse_clr();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 4'h0);
      cycle();
      drive(1'b1, 8'(8'hE0 + k), (k == 0), 1'b1, 4'(k + 1));
      cycle();
      total++;
      if (db_count !== CNT_W'(k + 1) || sb_count !== '0) begin
        bad++; $display("FAIL alarm_counts k=%0d got db=%0d sb=%0d required db=%0d sb=0", k, db_count, sb_count, k + 1);
      end
      total++;
      if (alarm !== (k == 3)) begin bad++; $display("FAIL alarm_level k=%0d got=%b required=%b", k, alarm, (k == 3)); end
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 4'h0);
      cycle();
    end
    total++; if (alarm !== 1'b1) begin bad++; $display("FAIL alarm_sticky got=%b required=1", alarm); end
    pulse_clr();
    total++;
    if (alarm !== 1'b0 || db_count !== '0 || sb_count !== '0) begin
      bad++; $display("FAIL alarm_clr got alarm=%b db=%0d sb=%0d required 0/0/0", alarm, db_count, sb_count);
    end
    drain();
  endtask

  task automatic test_window();
    int alarm_seen;
    out_ready = 1'b1;
    alarm_seen = 0;
    pulse_clr();
    drive(1'b1, 8'h11, 1'b0, 1'b1, 4'h3);
    cycle();
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 4'h0);
      cycle();
      if (alarm !== 1'b0) alarm_seen++;
    end
    total++; if (alarm_seen != 0) begin bad++; $display("FAIL window_alarm_seen got=%0d required=0", alarm_seen); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'h22, 1'b0, 1'b1, 4'h5);
      cycle();
      total++;
      if (alarm !== (m_state == 2)) begin
        bad++; $display("FAIL window_new_alarm k=%0d got=%b required=%b", k, alarm, (m_state == 2));
      end
    end
    pulse_clr();
    drain();
  endtask

  task automatic test_backpressure();
    int acc_n;
    acc_n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h30 + acc_n), 1'b0, 1'b0, 4'h0);
      cycle();
      if (last_acc) acc_n++;
    end
    total++; if (acc_n != 2) begin bad++; $display("FAIL bp_accepts got=%0d required=2", acc_n); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h30) begin
      bad++; $display("FAIL bp_hold got valid=%b data=%h required 1/30", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h30 + acc_n), 1'b0, 1'b0, 4'h0);
      cycle();
      if (last_acc) acc_n++;
    end
    drain();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0, 4'h1);
      cycle();
    end
    total++; if (sb_count !== CNT_W'(15)) begin bad++; $display("FAIL sat_sb got=%0d required=15", sb_count); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1, 4'h2);
      cycle();
    end
    total++; if (db_count !== CNT_W'(15)) begin bad++; $display("FAIL sat_db got=%0d required=15", db_count); end
    total++; if (sb_count !== CNT_W'(15)) begin bad++; $display("FAIL sat_sb_hold got=%0d required=15", sb_count); end
    pulse_clr();
    drain();
  endtask

  task automatic test_clr_accept();
    out_ready = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0, 4'h9);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_corr !== 1'b1) begin
      bad++; $display("FAIL clracc_fwd got valid=%b data=%h corr=%b required 1/5a/1", out_valid, out_data, out_corr);
    end
    total++; if (sb_count !== '0) begin bad++; $display("FAIL clracc_sb got=%0d required=0", sb_count); end
`ifdef HAMM_SYNDROME_LOG_EN
    total++; if (last_syndrome !== 4'h0) begin bad++; $display("FAIL clracc_syn got=%h required=0", last_syndrome); end
`endif
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), 4'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 79) == 0);
      cycle();
      total++;
      if (sb_count !== CNT_W'(m_sb) || db_count !== CNT_W'(m_db)) begin
        bad++; $display("FAIL rand_counts i=%0d got sb=%0d db=%0d required sb=%0d db=%0d", i, sb_count, db_count, m_sb, m_db);
      end
      total++;
      if (alarm !== (m_state == 2)) begin bad++; $display("FAIL rand_alarm i=%0d got=%b required=%b", i, alarm, (m_state == 2)); end
`ifdef HAMM_SYNDROME_LOG_EN
      total++;
      if (last_syndrome !== m_syn) begin bad++; $display("FAIL rand_syn i=%0d got=%h required=%h", i, last_syndrome, m_syn); end
`endif
    end
    clr = 1'b0;
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b0, 4'hC);
    cycle();
    drive(1'b1, 8'h88, 1'b0, 1'b1, 4'hD);
    cycle();
    drive(1'b1, 8'h99, 1'b0, 1'b0, 4'h0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_corr !== 1'b0) begin
      bad++; $display("FAIL midrst_path got rdy=%b vld=%b data=%h corr=%b required 0/0/00/0", in_ready, out_valid, out_data, out_corr);
    end
    total++;
    if (sb_count !== '0 || db_count !== '0 || alarm !== 1'b0) begin
      bad++; $display("FAIL midrst_stats got sb=%0d db=%0d alarm=%b required 0/0/0", sb_count, db_count, alarm);
    end
`ifdef HAMM_SYNDROME_LOG_EN
    total++; if (last_syndrome !== 4'h0) begin bad++; $display("FAIL midrst_syn got=%h required=0", last_syndrome); end
`endif
    drive(1'b0, 8'h00, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale i=%0d got=%b required=0", i, out_valid); end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_single();
    test_alarm();
    test_window();
    test_backpressure();
    test_saturate();
    test_clr_accept();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
